qdec_bin_arbiter: RTL and testbench
===================================

# qdec_bin_arbiter

Round-robin arbiter that shares the single CABAC bin-decoding engine among the CABAC syntax sub-FSMs: CU, trafo, TU, SAO and similar. Each requester issues one-bin decode requests, each carrying a context address and a bypass flag. The arbiter forwards exactly one request at a time to the engine and routes the returned bin back to the requester that owns it. A lock option lets a requester hold the engine across a multi-bin syntax element so that the bins of one element are never interleaved with another requester's bins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 10: context address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester bin request
- req_ctx_addr  in  NUM_REQ*ADDR_W  packed context addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ep  in  NUM_REQ  bypass (EP) mode for the requested bin
- req_lock  in  NUM_REQ  keep the grant after the current bin
- req_ack  out  NUM_REQ  one-cycle pulse when a request is captured
- bin_out  out  1  decoded bin value
- bin_out_vld  out  NUM_REQ  one-hot pulse marking which requester owns bin_out
- grant_id  out  3  index of the current owner; valid while busy=1
- busy  out  1  high in any state other than IDLE
- bin_count  out  8  bins completed in the current grant session; saturates at 255
- err_spurious  out  1  sticky; set by ruiBin_vld arriving outside WAIT_BIN
- ctx_addr  out  ADDR_W  context address to the engine
- ctx_addr_vld  out  1  one-cycle pulse, coincident with dec_run
- dec_run  out  1  one-cycle pulse that starts the engine
- EPMode  out  1  bypass flag to the engine
- dec_rdy  in  1  engine ready to accept a new bin
- ruiBin  in  1  decoded bin from the engine
- ruiBin_vld  in  1  ruiBin is valid

## Operation
State machine states: IDLE, ISSUE, WAIT_BIN, LOCKED.

- **IDLE.** If any req_vld bit is set, select a requester by searching upward from rr_ptr, modulo NUM_REQ.
  - Latch g, req_ctx_addr[g] and req_ep[g].
  - Go to ISSUE.
- **ISSUE.** On entry, pulse req_ack[g] high for one cycle.
  - While dec_rdy=0, wait.
  - On the first cycle dec_rdy=1 is sampled, go to WAIT_BIN.
- **WAIT_BIN.** On entry, pulse dec_run and ctx_addr_vld high for one cycle; ctx_addr and EPMode carry the latched values.
  - On ruiBin_vld: bin_out=ruiBin, bin_out_vld[g]=1 for one cycle, and bin_count increments (saturating).
  - Then, if req_lock[g]=1, go to LOCKED.
  - Otherwise go to IDLE with rr_ptr=(g+1) mod NUM_REQ.
- **LOCKED.** Other requesters are ignored.
  - If req_vld[g]=1: latch the new address and EP flag, go to ISSUE.
  - Else if req_lock[g]=0: go to IDLE with rr_ptr=(g+1) mod NUM_REQ.
  - Else stay in LOCKED.

Requester rules:
- A requester holds req_vld, req_ctx_addr and req_ep stable until it sees req_ack.
- It drops req_vld on the cycle after req_ack, unless it intends another bin.
- ctx_addr and EPMode hold their last issued values between dec_run pulses.

bin_count:
- Clears to 0 on each transition from IDLE to ISSUE.
- Is not cleared on transitions from LOCKED to ISSUE.

Error and ordering rules:
- ruiBin_vld in any state other than WAIT_BIN: the bin is ignored and err_spurious is set. Only reset clears err_spurious.
- If ruiBin_vld and a new req_vld arrive in the same cycle, the bin is routed first; the new request is arbitrated in IDLE or LOCKED on a later cycle.

Reset, asserted at any time including mid-bin:
- state=IDLE, rr_ptr=0.
- All outputs are 0, including ctx_addr, grant_id, bin_count and err_spurious.
- Any bin returned after reset is released counts as spurious.

## Timing
- All outputs are registered.
- Minimum request-to-dec_run latency: 2 cycles.
  - Request sampled in IDLE at cycle T.
  - req_ack at T+1 (ISSUE, with dec_rdy=1).
  - dec_run at T+2.
- ruiBin_vld at cycle B gives bin_out_vld at B+1.
- IDLE is re-entered at B+1, so the next unlocked arbitration samples req_vld at B+1.
- Locked back-to-back bin: LOCKED at B+1 samples req_vld; ISSUE at B+2; dec_run at B+3 at the earliest.
- dec_rdy low in ISSUE stalls indefinitely; no timeout.
- busy rises on the ISSUE entry cycle and falls on the IDLE entry cycle.

## Test plan
- **Single request.** req_vld=4'b0100, addr 10'h05A, ep=0, dec_rdy=1.
  - req_ack[2] at T+1; dec_run with ctx_addr=10'h05A at T+2.
  - ruiBin=1 at B gives bin_out_vld=4'b0100 and bin_out=1 at B+1; busy drops at B+1.
- **Round-robin.** All four requesters held continuously, each re-requesting immediately after its ack.
  - Grant order 0,1,2,3,0; bin_out_vld visits each bit exactly once per 4 bins.
- **Lock.** Requester 1 with lock=1 requests 3 bins while requester 0 requests continuously.
  - 3 consecutive grants to requester 1; bin_count reaches 3.
  - Requester 0 is granted only after lock drops.
  - rr_ptr becomes 2.
- **Stall and spurious bin.** dec_rdy=0 for 10 cycles in ISSUE.
  - No dec_run until the cycle after dec_rdy rises.
  - A ruiBin_vld during the stall sets err_spurious; bin_out_vld stays 0.
- **Reset in WAIT_BIN.** Assert rst_n=0 asynchronously in WAIT_BIN.
  - All outputs are 0 immediately.
  - A bin returned after release sets err_spurious; the next request is granted starting from requester 0.
- **Bypass propagation.** req_ep=1 on requester 3.
  - EPMode=1 coincident with dec_run; the previous requester's EPMode=0 does not leak.

Source files
------------

// File: rtl/qdec_bin_arbiter.sv
// -----------------------------------------------------------------------------
// qdec_bin_arbiter
//
// Round-robin arbiter that shares one CABAC bin-decoding engine among several
// syntax sub-FSMs. Only one one-bin request is outstanding at the engine at
// any time. The bin that comes back is routed to the requester that owns it.
// A requester can hold req_lock high to keep the engine across consecutive
// bins of one syntax element, so its bins are never interleaved with another
// requester's bins.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   ADDR_W       context address width
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req_vld        per-requester bin request
//   req_ctx_addr   packed context addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ep         per-requester bypass flag
//   req_lock       per-requester "keep the grant after this bin"
//   req_ack        one-cycle pulse when a request is captured
//   bin_out        decoded bin value
//   bin_out_vld    one-hot pulse naming the owner of bin_out
//   grant_id       index of the current owner (meaningful while busy=1)
//   busy           high in every state except IDLE
//   bin_count      bins completed in the current grant session, saturating
//   err_spurious   sticky flag: a bin arrived while none was expected
//   ctx_addr       context address to the engine
//   ctx_addr_vld   pulse coincident with dec_run
//   dec_run        one-cycle engine start pulse
//   EPMode         bypass flag to the engine
//   dec_rdy        engine can accept a new bin
//   ruiBin         decoded bin from the engine
//   ruiBin_vld     ruiBin is valid
// -----------------------------------------------------------------------------
module qdec_bin_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ctx_addr,
    input  logic [NUM_REQ-1:0]        req_ep,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      bin_out,
    output logic [NUM_REQ-1:0]        bin_out_vld,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [7:0]                bin_count,
    output logic                      err_spurious,
    output logic [ADDR_W-1:0]         ctx_addr,
    output logic                      ctx_addr_vld,
    output logic                      dec_run,
    output logic                      EPMode,
    input  logic                      dec_rdy,
    input  logic                      ruiBin,
    input  logic                      ruiBin_vld
);

    // Per-requester vectors are widened to 8 entries so that a 3-bit
    // requester index can address them without width mismatches.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_BIN = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          grant_reg, grant_next;
    logic [2:0]          rr_ptr_reg, rr_ptr_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                ep_reg, ep_next;
    logic [NUM_REQ-1:0]  req_ack_reg, req_ack_next;
    logic                bin_out_reg, bin_out_next;
    logic [NUM_REQ-1:0]  bin_out_vld_reg, bin_out_vld_next;
    logic                busy_reg, busy_next;
    logic [7:0]          bin_count_reg, bin_count_next;
    logic                err_reg, err_next;
    logic                dec_run_reg, dec_run_next;

    logic [MAX_REQ-1:0]  vld_ext;
    logic [MAX_REQ-1:0]  ep_ext;
    logic [MAX_REQ-1:0]  lock_ext;
    logic [ADDR_W-1:0]   addr_arr [MAX_REQ];

    // Unpack the per-requester inputs; unused slots read as zero.
    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_used
                assign vld_ext[gi]  = req_vld[gi];
                assign ep_ext[gi]   = req_ep[gi];
                assign lock_ext[gi] = req_lock[gi];
                assign addr_arr[gi] = req_ctx_addr[gi*ADDR_W +: ADDR_W];
            end else begin : g_unused
                assign vld_ext[gi]  = 1'b0;
                assign ep_ext[gi]   = 1'b0;
                assign lock_ext[gi] = 1'b0;
                assign addr_arr[gi] = '0;
            end
        end
    endgenerate

    // rot_idx[k] is the requester examined k-th when searching upward from
    // rr_ptr, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
    logic [3:0] rot_sum [NUM_REQ];
    logic [2:0] rot_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
            assign rot_sum[gi] = {1'b0, rr_ptr_reg} + 4'(gi);
            assign rot_idx[gi] = (rot_sum[gi] >= 4'(NUM_REQ))
                                 ? 3'(rot_sum[gi] - 4'(NUM_REQ))
                                 : rot_sum[gi][2:0];
        end
    endgenerate

    logic       arb_found;
    logic [2:0] arb_idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vld_ext[rot_idx[k]]) begin
                arb_found = 1'b1;
                arb_idx   = rot_idx[k];
            end
        end
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v = 8'd1 << idx;
        return v[NUM_REQ-1:0];
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        rr_ptr_next      = rr_ptr_reg;
        addr_next        = addr_reg;
        ep_next          = ep_reg;
        req_ack_next     = '0;
        bin_out_next     = bin_out_reg;
        bin_out_vld_next = '0;
        bin_count_next   = bin_count_reg;
        err_next         = err_reg;
        dec_run_next     = 1'b0;

        // A bin is only expected while waiting for one; anything else is
        // dropped and flagged.
        if (ruiBin_vld && (state_reg != WAIT_BIN)) begin
            err_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_next     = arb_idx;
                    addr_next      = addr_arr[arb_idx];
                    ep_next        = ep_ext[arb_idx];
                    bin_count_next = '0;
                    req_ack_next   = onehot(arb_idx);
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (dec_rdy) begin
                    dec_run_next = 1'b1;
                    state_next   = WAIT_BIN;
                end
            end
            WAIT_BIN: begin
                if (ruiBin_vld) begin
                    bin_out_next     = ruiBin;
                    bin_out_vld_next = onehot(grant_reg);
                    bin_count_next   = (bin_count_reg == 8'hFF) ? 8'hFF
                                                                : bin_count_reg + 8'd1;
                    if (lock_ext[grant_reg]) begin
                        state_next = LOCKED;
                    end else begin
                        rr_ptr_next = next_ptr(grant_reg);
                        state_next  = IDLE;
                    end
                end
            end
            LOCKED: begin
                // Only the lock owner is considered; the session count keeps
                // running across its bins.
                if (vld_ext[grant_reg]) begin
                    addr_next    = addr_arr[grant_reg];
                    ep_next      = ep_ext[grant_reg];
                    req_ack_next = onehot(grant_reg);
                    state_next   = ISSUE;
                end else if (!lock_ext[grant_reg]) begin
                    rr_ptr_next = next_ptr(grant_reg);
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            rr_ptr_reg      <= '0;
            addr_reg        <= '0;
            ep_reg          <= 1'b0;
            req_ack_reg     <= '0;
            bin_out_reg     <= 1'b0;
            bin_out_vld_reg <= '0;
            busy_reg        <= 1'b0;
            bin_count_reg   <= '0;
            err_reg         <= 1'b0;
            dec_run_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            rr_ptr_reg      <= rr_ptr_next;
            addr_reg        <= addr_next;
            ep_reg          <= ep_next;
            req_ack_reg     <= req_ack_next;
            bin_out_reg     <= bin_out_next;
            bin_out_vld_reg <= bin_out_vld_next;
            busy_reg        <= busy_next;
            bin_count_reg   <= bin_count_next;
            err_reg         <= err_next;
            dec_run_reg     <= dec_run_next;
        end
    end

    assign req_ack      = req_ack_reg;
    assign bin_out      = bin_out_reg;
    assign bin_out_vld  = bin_out_vld_reg;
    assign grant_id     = grant_reg;
    assign busy         = busy_reg;
    assign bin_count    = bin_count_reg;
    assign err_spurious = err_reg;
    assign ctx_addr     = addr_reg;
    assign ctx_addr_vld = dec_run_reg;
    assign dec_run      = dec_run_reg;
    assign EPMode       = ep_reg;

endmodule

// File: tb/tb_qdec_bin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qdec_bin_arbiter
//
// Directed bench for qdec_bin_arbiter (NUM_REQ=4, ADDR_W=10). Inputs change
// 1 time unit after a rising edge and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_qdec_bin_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*ADDR_W-1:0] req_ctx_addr;
    logic [NUM_REQ-1:0]        req_ep;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      bin_out;
    logic [NUM_REQ-1:0]        bin_out_vld;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [7:0]                bin_count;
    logic                      err_spurious;
    logic [ADDR_W-1:0]         ctx_addr;
    logic                      ctx_addr_vld;
    logic                      dec_run;
    logic                      EPMode;
    logic                      dec_rdy;
    logic                      ruiBin;
    logic                      ruiBin_vld;

    int checks   = 0;
    int failures = 0;

    qdec_bin_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_ctx_addr (req_ctx_addr),
        .req_ep       (req_ep),
        .req_lock     (req_lock),
        .req_ack      (req_ack),
        .bin_out      (bin_out),
        .bin_out_vld  (bin_out_vld),
        .grant_id     (grant_id),
        .busy         (busy),
        .bin_count    (bin_count),
        .err_spurious (err_spurious),
        .ctx_addr     (ctx_addr),
        .ctx_addr_vld (ctx_addr_vld),
        .dec_run      (dec_run),
        .EPMode       (EPMode),
        .dec_rdy      (dec_rdy),
        .ruiBin       (ruiBin),
        .ruiBin_vld   (ruiBin_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int idx, input logic [ADDR_W-1:0] a);
        req_ctx_addr[idx*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    logic [3:0] seen;

    initial begin
        rst_n        = 1'b0;
        req_vld      = '0;
        req_ctx_addr = '0;
        req_ep       = '0;
        req_lock     = '0;
        dec_rdy      = 1'b1;
        ruiBin       = 1'b0;
        ruiBin_vld   = 1'b0;
        seen         = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_ack",       32'(req_ack),      32'd0);
        chk("rst_grant",     32'(grant_id),     32'd0);
        chk("rst_count",     32'(bin_count),    32'd0);
        chk("rst_err",       32'(err_spurious), 32'd0);
        chk("rst_ctx_addr",  32'(ctx_addr),     32'd0);
        chk("rst_dec_run",   32'(dec_run),      32'd0);
        chk("rst_binvld",    32'(bin_out_vld),  32'd0);
        #2 rst_n = 1'b1;
        step();
        $display("reset: busy=%0d err=%0d", busy, err_spurious);

        // ---------------- single request ----------------
        set_addr(2, 10'h05A);
        req_vld = 4'b0100;
        step();                                    // T+1
        chk("single_ack",     32'(req_ack),  32'h4);
        chk("single_grant",   32'(grant_id), 32'd2);
        chk("single_busy",    32'(busy),     32'd1);
        chk("single_norun",   32'(dec_run),  32'd0);
        step();                                    // T+2
        req_vld = '0;
        chk("single_run",     32'(dec_run),      32'd1);
        chk("single_ctxvld",  32'(ctx_addr_vld), 32'd1);
        chk("single_addr",    32'(ctx_addr),     32'h05A);
        chk("single_ep",      32'(EPMode),       32'd0);
        chk("single_ackoff",  32'(req_ack),      32'd0);
        ruiBin = 1'b1; ruiBin_vld = 1'b1;
        step();                                    // B+1
        ruiBin_vld = 1'b0;
        chk("single_binvld",  32'(bin_out_vld), 32'h4);
        chk("single_bin",     32'(bin_out),     32'd1);
        chk("single_busyoff", 32'(busy),        32'd0);
        chk("single_count",   32'(bin_count),   32'd1);
        $display("single: grant=2 addr=%0h bin=%0d", ctx_addr, bin_out);

        // ---------------- round-robin ----------------
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 10'(32'h100 + i));
        req_vld = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();                                // ISSUE
            chk("rr_ack",   32'(req_ack),  32'(1 << (n % 4)));
            chk("rr_grant", 32'(grant_id), 32'(n % 4));
            step();                                // WAIT_BIN
            chk("rr_run",   32'(dec_run),  32'd1);
            chk("rr_addr",  32'(ctx_addr), 32'(32'h100 + (n % 4)));
            ruiBin = n[0]; ruiBin_vld = 1'b1;
            if (n == 4) req_vld = '0;
            step();                                // IDLE
            ruiBin_vld = 1'b0;
            chk("rr_binvld", 32'(bin_out_vld), 32'(1 << (n % 4)));
            chk("rr_bin",    32'(bin_out),     32'(n % 2));
            if (n < 4) seen = seen | bin_out_vld;
            $display("rr: bin %0d grant=%0d bin_out_vld=%b", n, grant_id, bin_out_vld);
        end
        chk("rr_coverage", 32'(seen), 32'hF);

        // ---------------- lock ----------------
        // Pointer sits at 1 here; requester 1 holds the engine for 3 bins.
        set_addr(0, 10'h0AA);
        set_addr(1, 10'h200);
        req_vld  = 4'b0011;
        req_lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();                                // ISSUE
            chk("lock_ack",   32'(req_ack),   32'h2);
            chk("lock_grant", 32'(grant_id),  32'd1);
            chk("lock_count", 32'(bin_count), 32'(k));
            step();                                // WAIT_BIN
            chk("lock_run",   32'(dec_run),   32'd1);
            chk("lock_addr",  32'(ctx_addr),  32'(32'h200 + k));
            ruiBin = k[0]; ruiBin_vld = 1'b1;
            if (k == 2) req_lock = '0;
            step();                                // LOCKED or IDLE
            ruiBin_vld = 1'b0;
            chk("lock_binvld", 32'(bin_out_vld), 32'h2);
            chk("lock_cnt2",   32'(bin_count),   32'(k + 1));
            chk("lock_busy",   32'(busy),        32'(k < 2 ? 1 : 0));
            if (k < 2) set_addr(1, 10'(32'h200 + k + 1));
            $display("lock: bin %0d count=%0d busy=%0d", k, bin_count, busy);
        end
        // Both 0 and 1 still request; pointer at 2 must pick requester 0.
        step();
        chk("unlock_ack",   32'(req_ack),   32'h1);
        chk("unlock_grant", 32'(grant_id),  32'd0);
        chk("unlock_count", 32'(bin_count), 32'd0);
        step();
        chk("unlock_addr",  32'(ctx_addr),  32'h0AA);
        ruiBin = 1'b1; ruiBin_vld = 1'b1;
        req_vld = '0;
        step();
        ruiBin_vld = 1'b0;
        chk("unlock_binvld", 32'(bin_out_vld), 32'h1);
        $display("unlock: requester 0 served after lock");

        // ---------------- stall and spurious bin ----------------
        dec_rdy = 1'b0;
        set_addr(2, 10'h033);
        req_vld = 4'b0100;
        step();                                    // ISSUE entry (S)
        chk("stall_ack", 32'(req_ack),      32'h4);
        chk("stall_err0", 32'(err_spurious), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) req_vld = '0;
            chk("stall_norun", 32'(dec_run), 32'd0);
            chk("stall_busy",  32'(busy),    32'd1);
            if (i == 4) begin
                ruiBin_vld = 1'b0;
                chk("spur_err",    32'(err_spurious), 32'd1);
                chk("spur_binvld", 32'(bin_out_vld),  32'd0);
            end
            if (i == 3) begin
                ruiBin = 1'b1; ruiBin_vld = 1'b1;
            end
            if (i == 10) dec_rdy = 1'b1;
        end
        step();
        chk("stall_run",  32'(dec_run),  32'd1);
        chk("stall_addr", 32'(ctx_addr), 32'h033);
        ruiBin = 1'b0; ruiBin_vld = 1'b1;
        step();
        ruiBin_vld = 1'b0;
        chk("stall_binvld", 32'(bin_out_vld),  32'h4);
        chk("stall_bin",    32'(bin_out),      32'd0);
        chk("stall_sticky", 32'(err_spurious), 32'd1);
        $display("stall: err_spurious=%0d", err_spurious);

        // ---------------- reset in WAIT_BIN ----------------
        set_addr(1, 10'h3FF);
        req_vld = 4'b0010;
        step();
        chk("rstw_ack", 32'(req_ack), 32'h2);
        step();
        req_vld = '0;
        chk("rstw_run", 32'(dec_run), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_run0",  32'(dec_run),      32'd0);
        chk("rstw_busy",  32'(busy),         32'd0);
        chk("rstw_addr",  32'(ctx_addr),     32'd0);
        chk("rstw_grant", 32'(grant_id),     32'd0);
        chk("rstw_err",   32'(err_spurious), 32'd0);
        chk("rstw_ctxv",  32'(ctx_addr_vld), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        ruiBin = 1'b1; ruiBin_vld = 1'b1;
        step();
        ruiBin_vld = 1'b0;
        chk("rstw_spur",   32'(err_spurious), 32'd1);
        chk("rstw_binvld", 32'(bin_out_vld),  32'd0);
        set_addr(3, 10'h123);
        set_addr(1, 10'h111);
        req_vld = 4'b1010;
        step();
        chk("rstw_grant1", 32'(grant_id), 32'd1);
        chk("rstw_ack1",   32'(req_ack),  32'h2);
        step();
        chk("rstw_addr1",  32'(ctx_addr), 32'h111);
        ruiBin_vld = 1'b1;
        req_vld = '0;
        step();
        ruiBin_vld = 1'b0;
        chk("rstw_binvld1", 32'(bin_out_vld), 32'h2);
        $display("reset-mid-bin: restart grant=%0d", grant_id);

        // ---------------- bypass propagation ----------------
        set_addr(3, 10'h2C4);
        req_ep  = 4'b1000;
        req_vld = 4'b1000;
        step();
        chk("ep_ack",   32'(req_ack),  32'h8);
        chk("ep_grant", 32'(grant_id), 32'd3);
        step();
        req_vld = '0;
        chk("ep_run",   32'(dec_run),  32'd1);
        chk("ep_mode",  32'(EPMode),   32'd1);
        chk("ep_addr",  32'(ctx_addr), 32'h2C4);
        ruiBin_vld = 1'b1;
        step();
        ruiBin_vld = 1'b0;
        req_ep = '0;
        chk("ep_binvld", 32'(bin_out_vld), 32'h8);
        chk("ep_hold",   32'(EPMode),      32'd1);
        set_addr(0, 10'h011);
        req_vld = 4'b0001;
        step();
        chk("ep0_ack",  32'(req_ack), 32'h1);
        step();
        req_vld = '0;
        chk("ep0_run",  32'(dec_run),  32'd1);
        chk("ep0_mode", 32'(EPMode),   32'd0);
        chk("ep0_addr", 32'(ctx_addr), 32'h011);
        ruiBin_vld = 1'b1;
        step();
        ruiBin_vld = 1'b0;
        chk("ep0_binvld", 32'(bin_out_vld), 32'h1);
        $display("bypass: EPMode now %0d", EPMode);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
